// File: rtl/kfps2kb_pkg.sv
// Shared types, protocol constants and the set-2 to set-1 translation for the
// PS/2-to-XT keyboard queue.
package kfps2kb_pkg;

  typedef enum logic [2:0] {
    DEC_IDLE,
    DEC_BRK,
    DEC_EXT,
    DEC_EXT_BRK,
    DEC_E1_SKIP
  } dec_state_t;

  localparam logic [7:0] PS2_BREAK       = 8'hF0;
  localparam logic [7:0] PS2_EXT0        = 8'hE0;
  localparam logic [7:0] PS2_EXT1        = 8'hE1;
  localparam logic [7:0] PS2_ACK         = 8'hFA;
  localparam logic [7:0] PS2_ECHO        = 8'hEE;
  localparam logic [7:0] PS2_FAKE_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_FAKE_RSHIFT = 8'h59;
  localparam logic [7:0] XT_ERROR        = 8'hFF;
  localparam logic [7:0] XT_BREAK_BIT    = 8'h80;

  // Number of set-2 bytes that follow E1 in the pause make sequence.
  localparam logic [2:0]  E1_SKIP_LEN  = 3'd7;
  localparam logic [47:0] XT_PAUSE_SEQ = 48'hE1_1D_45_E1_9D_C5;

  // Set-2 make code to set-1 make code; unknown low codes map to 00.
  function automatic logic [7:0] set2_to_set1(input logic [7:0] code);
    logic [7:0] r;
    r = 8'h00;
    if (code > 8'h8F) begin
      r = code;
    end else begin
      case (code)
        8'h00: r = 8'hFF;  8'h01: r = 8'h43;  8'h03: r = 8'h3F;  8'h04: r = 8'h3D;
        8'h05: r = 8'h3B;  8'h06: r = 8'h3C;  8'h07: r = 8'h58;  8'h09: r = 8'h44;
        8'h0A: r = 8'h42;  8'h0B: r = 8'h40;  8'h0C: r = 8'h3E;  8'h0D: r = 8'h0F;
        8'h0E: r = 8'h29;  8'h11: r = 8'h38;  8'h12: r = 8'h2A;  8'h14: r = 8'h1D;
        8'h15: r = 8'h10;  8'h16: r = 8'h02;  8'h1A: r = 8'h2C;  8'h1B: r = 8'h1F;
        8'h1C: r = 8'h1E;  8'h1D: r = 8'h11;  8'h1E: r = 8'h03;  8'h21: r = 8'h2E;
        8'h22: r = 8'h2D;  8'h23: r = 8'h20;  8'h24: r = 8'h12;  8'h25: r = 8'h05;
        8'h26: r = 8'h04;  8'h29: r = 8'h39;  8'h2A: r = 8'h2F;  8'h2B: r = 8'h21;
        8'h2C: r = 8'h14;  8'h2D: r = 8'h13;  8'h2E: r = 8'h06;  8'h31: r = 8'h31;
        8'h32: r = 8'h30;  8'h33: r = 8'h23;  8'h34: r = 8'h22;  8'h35: r = 8'h15;
        8'h36: r = 8'h07;  8'h3A: r = 8'h32;  8'h3B: r = 8'h24;  8'h3C: r = 8'h16;
        8'h3D: r = 8'h08;  8'h3E: r = 8'h09;  8'h41: r = 8'h33;  8'h42: r = 8'h25;
        8'h43: r = 8'h17;  8'h44: r = 8'h18;  8'h45: r = 8'h0B;  8'h46: r = 8'h0A;
        8'h49: r = 8'h34;  8'h4A: r = 8'h35;  8'h4B: r = 8'h26;  8'h4C: r = 8'h27;
        8'h4D: r = 8'h19;  8'h4E: r = 8'h0C;  8'h52: r = 8'h28;  8'h54: r = 8'h1A;
        8'h55: r = 8'h0D;  8'h58: r = 8'h3A;  8'h59: r = 8'h36;  8'h5A: r = 8'h1C;
        8'h5B: r = 8'h1B;  8'h5D: r = 8'h2B;  8'h66: r = 8'h0E;  8'h69: r = 8'h4F;
        8'h6B: r = 8'h4B;  8'h6C: r = 8'h47;  8'h70: r = 8'h52;  8'h71: r = 8'h53;
        8'h72: r = 8'h50;  8'h73: r = 8'h4C;  8'h74: r = 8'h4D;  8'h75: r = 8'h48;
        8'h76: r = 8'h01;  8'h77: r = 8'h45;  8'h78: r = 8'h57;  8'h79: r = 8'h4E;
        8'h7A: r = 8'h51;  8'h7B: r = 8'h4A;  8'h7C: r = 8'h37;  8'h7D: r = 8'h49;
        8'h7E: r = 8'h46;  8'h83: r = 8'h41;
        default: r = 8'h00;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/kfps2kb_sync_fifo.sv
// Synchronous FIFO with occupancy count.
//   clock, reset_n     : clock, synchronous active-low reset
//   push, push_data    : write request (accepted when not full, or when popping)
//   pop, head          : read request and current head entry
//   count, full, empty : occupancy status (registered)
module kfps2kb_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign head  = mem[rd_ptr];
  assign count = count_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/kfps2kb_xt_queue.sv
// PS/2 set-2 byte decoder, XT set-1 translator and queued irq/clear presenter.
//   clock, reset_n          : clock, synchronous active-low reset
//   rx_valid/rx_data        : received PS/2 byte strobe and data
//   rx_error                : receive error strobe
//   clear_keycode           : pop of the presented byte
//   irq, keycode            : presented XT byte (keycode 00 while irq low)
//   pause_core              : core-pause request toggled by the pause key release
//   overrun                 : one-cycle pulse when a byte is lost
//   fifo_count              : queue occupancy
module kfps2kb_xt_queue
  import kfps2kb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned IRQ_GAP      = 16,
  parameter bit          PAUSE_ENABLE = 1'b1,
  parameter logic [7:0]  PAUSE_KEY    = 8'h78
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_error,
  input  logic                          clear_keycode,
  output logic                          irq,
  output logic [7:0]                    keycode,
  output logic                          pause_core,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned GW = (IRQ_GAP < 1) ? 1 : $clog2(IRQ_GAP + 1);

  dec_state_t  state_q, state_d;
  logic [2:0]  skip_q, skip_d;
  logic [47:0] ebuf_q, ebuf_d;
  logic [2:0]  elen_q, elen_d;
  logic        pause_q, pause_d;
  logic        overrun_q, overrun_d;
  logic [47:0] new_buf;
  logic [2:0]  new_len;

  logic          irq_q;
  logic [7:0]    keycode_q;
  logic [GW-1:0] gap_q;

  logic [7:0]    t_code;
  logic          is_fake;
  logic          busy;
  logic          fifo_push_c;
  logic [7:0]    fifo_data_c;
  logic          fifo_pop_c;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_cnt;

  assign t_code      = set2_to_set1(rx_data);
  assign is_fake     = (rx_data == PS2_FAKE_LSHIFT) || (rx_data == PS2_FAKE_RSHIFT);
  assign busy        = (elen_q != 3'd0);
  assign fifo_push_c = busy;
  assign fifo_pop_c  = irq_q && clear_keycode;
  // The entry that fills the last slot is replaced by the overflow code.
  assign fifo_data_c = (fifo_pop_c ? fifo_full : (fifo_cnt == CW'(FIFO_DEPTH - 1)))
                       ? XT_ERROR : ebuf_q[47:40];

  // Decoder next state and emitter load/drain
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    ebuf_d    = ebuf_q;
    elen_d    = elen_q;
    pause_d   = pause_q;
    overrun_d = 1'b0;
    new_buf   = '0;
    new_len   = 3'd0;

    if (busy) begin
      ebuf_d = {ebuf_q[39:0], 8'h00};
      elen_d = elen_q - 3'd1;
    end
    if (fifo_push_c && fifo_full && !fifo_pop_c) overrun_d = 1'b1;

    if (rx_error) begin
      state_d = DEC_IDLE;
      if (busy) begin
        overrun_d = 1'b1;
      end else begin
        new_buf = {XT_ERROR, 40'h0};
        new_len = 3'd1;
      end
    end else if (rx_valid) begin
      if (busy) begin
        overrun_d = 1'b1;
      end else begin
        case (state_q)
          DEC_IDLE: begin
            if (rx_data == PS2_BREAK) begin
              state_d = DEC_BRK;
            end else if (rx_data == PS2_EXT0) begin
              state_d = DEC_EXT;
            end else if (rx_data == PS2_EXT1) begin
              state_d = DEC_E1_SKIP;
              skip_d  = E1_SKIP_LEN;
            end else if (rx_data != PS2_ACK && rx_data != PS2_ECHO && rx_data != PAUSE_KEY) begin
              new_buf = {t_code, 40'h0};
              new_len = 3'd1;
            end
          end
          DEC_BRK: begin
            state_d = DEC_IDLE;
            if (rx_data == PAUSE_KEY) begin
              if (PAUSE_ENABLE) pause_d = !pause_q;
            end else begin
              new_buf = {t_code | XT_BREAK_BIT, 40'h0};
              new_len = 3'd1;
            end
          end
          DEC_EXT: begin
            if (rx_data == PS2_BREAK) begin
              state_d = DEC_EXT_BRK;
            end else begin
              state_d = DEC_IDLE;
              if (!is_fake) begin
                new_buf = {PS2_EXT0, t_code, 32'h0};
                new_len = 3'd2;
              end
            end
          end
          DEC_EXT_BRK: begin
            state_d = DEC_IDLE;
            if (!is_fake) begin
              new_buf = {PS2_EXT0, t_code | XT_BREAK_BIT, 32'h0};
              new_len = 3'd2;
            end
          end
          DEC_E1_SKIP: begin
            skip_d = skip_q - 3'd1;
            if (skip_q == 3'd1) begin
              state_d = DEC_IDLE;
              new_buf = XT_PAUSE_SEQ;
              new_len = 3'd6;
            end
          end
          default: state_d = DEC_IDLE;
        endcase
      end
    end

    // While paused, decoding continues but nothing is queued.
    if (new_len != 3'd0 && !pause_q) begin
      ebuf_d = new_buf;
      elen_d = new_len;
    end
  end

  // Decoder/emitter registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= DEC_IDLE;
      skip_q    <= 3'd0;
      ebuf_q    <= '0;
      elen_q    <= 3'd0;
      pause_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      ebuf_q    <= ebuf_d;
      elen_q    <= elen_d;
      pause_q   <= pause_d;
      overrun_q <= overrun_d;
    end
  end

  // Presentation handshake with enforced irq-low gap after each pop
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      irq_q     <= 1'b0;
      keycode_q <= 8'h00;
      gap_q     <= '0;
    end else if (fifo_pop_c) begin
      irq_q     <= 1'b0;
      keycode_q <= 8'h00;
      gap_q     <= GW'(IRQ_GAP);
    end else if (!irq_q) begin
      if (gap_q != '0) begin
        gap_q <= gap_q - GW'(1);
      end else if (!fifo_empty) begin
        irq_q     <= 1'b1;
        keycode_q <= fifo_head;
      end
    end
  end

  kfps2kb_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (fifo_push_c),
    .push_data (fifo_data_c),
    .pop       (fifo_pop_c),
    .head      (fifo_head),
    .count     (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign irq        = irq_q;
  assign keycode    = keycode_q;
  assign pause_core = pause_q;
  assign overrun    = overrun_q;
  assign fifo_count = fifo_cnt;

endmodule

// File: tb/tb_kfps2kb_xt_queue.sv
module tb_kfps2kb_xt_queue;

  localparam int unsigned GAP = 16;
  localparam int NK = 24;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rx_valid, rx_error, clear_keycode;
  logic [7:0] rx_data;
  logic       irq, pause_core, overrun;
  logic [7:0] keycode;
  logic [4:0] fifo_count;

  logic       rx4_valid, rx4_error, clear4;
  logic [7:0] rx4_data;
  logic       irq4, pause4, overrun4;
  logic [7:0] keycode4;
  logic [2:0] count4;

  int errors = 0;
  int checks = 0;
  int ov_cnt = 0;
  int ov4_cnt = 0;
  bit auto_clear = 1'b1;

  logic [7:0] exp_q [$];
  bit m_e0, m_f0, m_pause;
  int m_e1_left;

  logic [7:0] pool_k [NK] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42,
                              8'h4B, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                              8'h75, 8'h6B, 8'h74, 8'h72, 8'h12, 8'h59, 8'h5A, 8'h76};
  logic [7:0] pool_v [NK] = '{8'h1E, 8'h1F, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                              8'h26, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                              8'h48, 8'h4B, 8'h4D, 8'h50, 8'h2A, 8'h36, 8'h1C, 8'h01};

  kfps2kb_xt_queue #(.FIFO_DEPTH(16), .IRQ_GAP(GAP), .PAUSE_ENABLE(1'b1), .PAUSE_KEY(8'h78)) dut (
    .clock(clock), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_error(rx_error), .clear_keycode(clear_keycode), .irq(irq), .keycode(keycode),
    .pause_core(pause_core), .overrun(overrun), .fifo_count(fifo_count));

  kfps2kb_xt_queue #(.FIFO_DEPTH(4), .IRQ_GAP(GAP), .PAUSE_ENABLE(1'b1), .PAUSE_KEY(8'h78)) dut4 (
    .clock(clock), .reset_n(reset_n), .rx_valid(rx4_valid), .rx_data(rx4_data),
    .rx_error(rx4_error), .clear_keycode(clear4), .irq(irq4), .keycode(keycode4),
    .pause_core(pause4), .overrun(overrun4), .fifo_count(count4));

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: translation by table lookup, prefixes tracked as flags.
  function automatic logic [7:0] xlat(input logic [7:0] b);
    for (int i = 0; i < NK; i++) if (pool_k[i] == b) return pool_v[i];
    return 8'h00;
  endfunction

  function automatic void emit(input logic [7:0] b);
    if (!m_pause) exp_q.push_back(b);
  endfunction

  function automatic void model_rx(input logic [7:0] b);
    bit brk;
    if (m_e1_left > 0) begin
      m_e1_left--;
      if (m_e1_left == 0) begin
        emit(8'hE1); emit(8'h1D); emit(8'h45); emit(8'hE1); emit(8'h9D); emit(8'hC5);
      end
    end else if (m_e0) begin
      if (b == 8'hF0 && !m_f0) begin
        m_f0 = 1'b1;
      end else begin
        brk = m_f0;
        m_e0 = 1'b0;
        m_f0 = 1'b0;
        if (b != 8'h12 && b != 8'h59) begin
          emit(8'hE0);
          emit(brk ? (xlat(b) | 8'h80) : xlat(b));
        end
      end
    end else if (m_f0) begin
      m_f0 = 1'b0;
      if (b == 8'h78) m_pause = !m_pause;
      else emit(xlat(b) | 8'h80);
    end else begin
      case (b)
        8'hF0: m_f0 = 1'b1;
        8'hE0: m_e0 = 1'b1;
        8'hE1: m_e1_left = 7;
        8'hFA, 8'hEE, 8'h78: ;
        default: emit(xlat(b));
      endcase
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    rx_valid = 1'b1; rx_data = b;
    @(posedge clock); #1;
    rx_valid = 1'b0;
    model_rx(b);
    repeat (10) @(posedge clock);
  endtask

  task automatic send_error();
    @(posedge clock); #1;
    rx_error = 1'b1;
    @(posedge clock); #1;
    rx_error = 1'b0;
    m_e0 = 1'b0; m_f0 = 1'b0; m_e1_left = 0;
    emit(8'hFF);
    repeat (10) @(posedge clock);
  endtask

  task automatic send4(input logic [7:0] b);
    @(posedge clock); #1;
    rx4_valid = 1'b1; rx4_data = b;
    @(posedge clock); #1;
    rx4_valid = 1'b0;
    repeat (10) @(posedge clock);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || irq) && n < 4000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 4000) begin
      check("drain_timeout", exp_q.size(), 0);
    end
    repeat (4) @(negedge clock);
  endtask

  // Consumer: pops each presented byte after a random delay.
  initial begin
    clear_keycode = 1'b0;
    forever begin
      @(negedge clock);
      if (auto_clear && irq && reset_n) begin
        repeat ($urandom_range(0, 3)) @(negedge clock);
        @(posedge clock); #1;
        clear_keycode = 1'b1;
        @(posedge clock); #1;
        clear_keycode = 1'b0;
      end
    end
  end

  // Monitor: compares each newly presented byte with the scoreboard.
  initial begin
    bit irq_prev, had_pop;
    int low_cnt;
    logic [7:0] e;
    irq_prev = 1'b0; had_pop = 1'b0; low_cnt = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        irq_prev = 1'b0;
      end else begin
        if (irq && !irq_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_irq", int'(keycode), -1);
          end else begin
            e = exp_q.pop_front();
            check("keycode", int'(keycode), int'(e));
          end
          if (had_pop) check("irq_gap_ok", int'(low_cnt >= int'(GAP)), 1);
        end
        if (!irq && irq_prev) begin
          check("keycode_idle", int'(keycode), 0);
          had_pop = 1'b1;
          low_cnt = 0;
        end
        if (!irq) low_cnt++;
        if (overrun) ov_cnt++;
        if (overrun4) ov4_cnt++;
        irq_prev = irq;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp4 [4] = '{8'h02, 8'h03, 8'h04, 8'hFF};
    int n;
    int kind;
    logic [7:0] k;

    reset_n = 1'b0; rx_valid = 1'b0; rx_error = 1'b0; rx_data = 8'h00;
    rx4_valid = 1'b0; rx4_error = 1'b0; rx4_data = 8'h00; clear4 = 1'b0;
    m_e0 = 1'b0; m_f0 = 1'b0; m_pause = 1'b0; m_e1_left = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_irq", int'(irq), 0);
    check("rst_keycode", int'(keycode), 0);
    check("rst_pause", int'(pause_core), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_count", int'(fifo_count), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Overflow on the 4-deep instance, no pops.
    send4(8'h16); send4(8'h1E); send4(8'h26); send4(8'h25);
    check("ovf_count4", int'(count4), 4);
    check("ovf_no_overrun_yet", ov4_cnt, 0);
    send4(8'h2E);
    check("ovf_count4_after", int'(count4), 4);
    check("ovf_overrun_pulses", ov4_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      n = 0;
      @(negedge clock);
      while (!irq4 && n < 100) begin @(negedge clock); n++; end
      check("ovf_irq4", int'(irq4), 1);
      check("ovf_content", int'(keycode4), int'(exp4[i]));
      @(posedge clock); #1; clear4 = 1'b1;
      @(posedge clock); #1; clear4 = 1'b0;
    end
    repeat (30) @(negedge clock);
    check("ovf_empty4", int'(count4), 0);
    check("ovf_irq4_low", int'(irq4), 0);
    check("pause4_idle", int'(pause4), 0);

    // Make/break 'A'
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    drain();
    // Extended key and fake shift
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h12);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h12);
    drain();
    // Pause/Break key
    foreach (pool_v[i]) ;
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    drain();
    check("pause_seq_no_overrun", ov_cnt, 0);

    // Pause toggle
    send_byte(8'h78); send_byte(8'hF0); send_byte(8'h78);
    @(negedge clock);
    check("pause_on", int'(pause_core), 1);
    send_byte(8'h1C);
    repeat (40) @(negedge clock);
    check("paused_no_irq", int'(irq), 0);
    check("paused_count", int'(fifo_count), 0);
    send_byte(8'hF0); send_byte(8'h78);
    @(negedge clock);
    check("pause_off", int'(pause_core), 0);

    // Reset in the middle of an E0 sequence
    send_byte(8'hE0);
    @(posedge clock); #1;
    reset_n = 1'b0;
    m_e0 = 1'b0; m_f0 = 1'b0; m_pause = 1'b0; m_e1_left = 0;
    @(negedge clock);
    check("midrst_irq", int'(irq), 0);
    check("midrst_keycode", int'(keycode), 0);
    check("midrst_pause", int'(pause_core), 0);
    check("midrst_overrun", int'(overrun), 0);
    check("midrst_count", int'(fifo_count), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    send_byte(8'h1C);
    drain();

    // Receive error in the middle of an E0 sequence
    send_byte(8'hE0);
    send_error();
    send_byte(8'h1C);
    drain();

    // Randomized key traffic
    for (int ev = 0; ev < 150; ev++) begin
      kind = int'($urandom_range(0, 4));
      k = pool_k[$urandom_range(0, NK - 1)];
      case (kind)
        0: send_byte(k);
        1: begin send_byte(8'hF0); send_byte(k); end
        2: begin send_byte(8'hE0); send_byte(k); end
        3: begin send_byte(8'hE0); send_byte(8'hF0); send_byte(k); end
        default: begin
          if ($urandom_range(0, 1) == 1) send_byte(8'hE0);
          send_error();
        end
      endcase
      drain();
    end

    check("final_count", int'(fifo_count), 0);
    check("final_no_overrun", ov_cnt, 0);
    check("final_pause", int'(pause_core), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
